// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - sequential packed-BCD to binary converter (reverse double dabble)
module bcd_to_binary #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      binary,
  output logic                  done,
  output logic                  busy,
  output logic                  error
);

  localparam int WORK_W = 4*DIGITS + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, ADJUST, DONE} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WORK_W-1:0]   work_q;
  logic [WORK_W-1:0]   adj_d;
  logic                err_q;
  logic                in_err_d;
  logic [BIN_W-1:0]    binary_q;
  logic                done_q;
  logic                busy_q;
  logic                error_q;

  // Every BCD digit >= 8 drops by 3 in parallel; the binary field passes through.
  always_comb begin
    adj_d = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[BIN_W+4*i +: 4] >= 4'd8)
        adj_d[BIN_W+4*i +: 4] = work_q[BIN_W+4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    in_err_d = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9)
        in_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      err_q    <= 1'b0;
      binary_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (enable) begin
            work_q  <= {bcd_in, {BIN_W{1'b0}}};
            err_q   <= in_err_d;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          work_q  <= work_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          state_q <= ADJUST;
        end
        ADJUST: begin
          work_q  <= adj_d;
          state_q <= (cnt_q == CNT_W'(BIN_W)) ? DONE : SHIFT;
        end
        DONE: begin
          binary_q <= err_q ? '0 : work_q[BIN_W-1:0];
          error_q  <= err_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign binary = binary_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign error  = error_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb/tb_bcd_to_binary.sv - scoreboard bench for bcd_to_binary with decimal reference model
module tb_bcd_to_binary;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
  localparam int LAT    = 2*BIN_W + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [11:0]       bcd_in;
  logic [BIN_W-1:0]  binary;
  logic              done;
  logic              busy;
  logic              error;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [BIN_W-1:0]  q_bin[$];
  logic              q_err[$];
  int                q_acc[$];

  logic [BIN_W-1:0]  m_bin;
  logic              m_err;
  int                m_acc;

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .bcd_in (bcd_in),
    .binary (binary),
    .done   (done),
    .busy   (busy),
    .error  (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal interpretation of the digits; any digit above 9 poisons the result.
  task automatic model(input logic [11:0] v, output logic [BIN_W-1:0] b, output logic e);
    int val;
    int d;
    val = 0;
    e   = 1'b0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) e = 1'b1;
      val = val*10 + d;
    end
    b = e ? '0 : BIN_W'(val);
  endtask

  task automatic push_exp(input logic [11:0] v, input int acc_edge);
    logic [BIN_W-1:0] b;
    logic e;
    model(v, b, e);
    q_bin.push_back(b);
    q_err.push_back(e);
    q_acc.push_back(acc_edge);
  endtask

  function automatic logic [11:0] bcd_of(input int k);
    bcd_of = {4'(k/100), 4'((k/10)%10), 4'(k%10)};
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (q_bin.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with binary=%0d, expected no done (cycle %0d)", binary, cyc);
      end else begin
        m_bin = q_bin.pop_front();
        m_err = q_err.pop_front();
        m_acc = q_acc.pop_front();
        chk("binary", int'(binary), int'(m_bin));
        chk("error", int'(error), int'(m_err));
        chk("latency", cyc - m_acc, LAT);
      end
    end
  end

  // Called at the negedge after the accept edge; returns at the negedge showing done.
  task automatic wait_done(output int bcnt, output bit ok);
    int n;
    n = 0;
    bcnt = 0;
    while (!done && n < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      n++;
    end
    ok = done;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
    end
  endtask

  task automatic run_one(input logic [11:0] v, input bit chk_busy);
    int bc;
    bit ok;
    @(negedge clk);
    bcd_in = v;
    enable = 1'b1;
    push_exp(v, cyc + 1);
    @(negedge clk);
    enable = 1'b0;
    bcd_in = 12'($urandom);
    wait_done(bc, ok);
    if (ok && chk_busy) begin
      chk("busy_cycles", bc, LAT);
      chk("busy_at_done", int'(busy), 0);
    end
  endtask

  initial begin
    int bc;
    int prev;
    bit ok;
    logic [11:0] v;

    rst    = 1'b1;
    enable = 1'b0;
    bcd_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_binary", int'(binary), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_error", int'(error), 0);
    rst = 1'b0;

    run_one(12'h255, 1'b1);
    run_one(12'h999, 1'b1);
    run_one(12'h000, 1'b1);
    run_one(12'h1A3, 1'b1);
    run_one(12'h042, 1'b1);

    // Enable re-pulses during a conversion must be ignored.
    @(negedge clk);
    bcd_in = 12'h128;
    enable = 1'b1;
    push_exp(12'h128, cyc + 1);
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    bcd_in = 12'h777;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    bcd_in = 12'h777;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_done(bc, ok);
    repeat (30) @(negedge clk);

    // Reset five cycles into a conversion aborts it silently.
    @(negedge clk);
    bcd_in = 12'h500;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_binary", int'(binary), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    run_one(12'h500, 1'b1);

    // Exhaustive sweep with enable held high: back-to-back conversions.
    @(negedge clk);
    prev = -1;
    for (int k = 0; k < 1000; k++) begin
      bcd_in = bcd_of(k);
      enable = 1'b1;
      push_exp(bcd_in, cyc + 1);
      @(negedge clk);
      wait_done(bc, ok);
      if (!ok) break;
      chk("sweep_busy", bc, LAT);
      if (prev >= 0) chk("b2b_gap", cyc - prev, LAT + 1);
      prev = cyc;
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);

    // Random codes, including invalid digits, with random idle gaps.
    for (int k = 0; k < 300; k++) begin
      v = 12'($urandom_range(0, 4095));
      run_one(v, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (30) @(negedge clk);
    chk("scoreboard_drained", q_bin.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Sequential BCD-to-binary converter using reverse double dabble: shift right one bit per iteration, then subtract 3 from every BCD digit >= 8.
- Inverse of the team's binary-to-BCD double dabble block. Sits on the same display/keypad datapath, turning packed BCD entry values back into binary for arithmetic.
- Uses the same enable/done handshake style, plus an explicit busy flag and an invalid-digit error flag.

Parameters:
- DIGITS, 3, number of packed BCD input digits.
- BIN_W, 10, binary output width. Must satisfy 10^DIGITS - 1 < 2^BIN_W (3 digits gives 999, which fits in 10 bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  start request. Sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD; digit 0 is in [3:0].
- binary  output  BIN_W  converted value (reg). Holds its value until the next completion.
- done  output  1  one-cycle pulse when binary and error are valid.
- busy  output  1  high from the accept edge until the DONE state exits.
- error  output  1  set with done if any input digit was > 9. Holds its value until the next completion.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - binary = 0, done = 0, busy = 0, error = 0.
  - state = IDLE, iteration counter = 0, work register = 0.
  - Reset mid-conversion aborts the conversion. Outputs return to reset values at that edge, and no done is produced.
- Work register: 4*DIGITS + BIN_W bits. The BCD field is the upper 4*DIGITS bits; the binary field is the lower BIN_W bits.
- States: IDLE, SHIFT, ADJUST, DONE.
- IDLE:
  - done <= 0.
  - If enable: load work = {bcd_in, BIN_W'0}, latch err_q = (any digit > 9), busy <= 1, counter <= 0, state <= SHIFT.
- SHIFT: work <= work >> 1 (logical, MSB filled with 0); counter <= counter + 1; state <= ADJUST.
- ADJUST:
  - Each BCD-field digit >= 8 is decremented by 3, independently, all in the same cycle.
  - Digits are evaluated on the post-shift value; no inter-digit borrow is required.
  - If counter == BIN_W: state <= DONE. Otherwise: state <= SHIFT.
- DONE:
  - binary <= err_q ? 0 : work[BIN_W-1:0].
  - error <= err_q; done <= 1; busy <= 0; state <= IDLE.
- Latency:
  - Accept edge = E. DONE is entered at E + 2*BIN_W. Outputs update and done rises at E + 2*BIN_W + 1.
  - With defaults, done is high 21 edges after accept. done is high for exactly one cycle.
- Enable handling:
  - enable while busy is ignored; no queueing.
  - enable held high during the done cycle is accepted (state is IDLE). done then falls at that same edge, giving back-to-back operation.
  - bcd_in is sampled only at the accept edge and may change afterwards.
- Arithmetic: after BIN_W iterations the BCD field is zero for valid input. Invalid digits still run through the iterations (fixed latency), but the result is forced to 0.
- Counter width: clog2(BIN_W+1). No wrap occurs within a conversion.

Test Plan:
- Reset, then bcd_in = 12'h255, pulse enable -> busy for 21 cycles; done pulse with binary = 10'd255, error = 0.
- bcd_in = 12'h999 -> binary = 10'd999. bcd_in = 12'h000 -> binary = 0, done still pulses at the same latency.
- bcd_in = 12'h1A3 (invalid digit) -> error = 1, binary = 0, done at the normal latency. A following valid 12'h042 -> binary = 42, error = 0.
- enable re-pulsed with bcd_in = 12'h777 at cycles 3 and 10 of a 12'h128 conversion -> ignored; only one done, binary = 128. enable held high continuously -> back-to-back dones exactly 22 cycles apart.
- rst asserted 5 cycles into a 12'h500 conversion -> next edge shows busy = 0, done = 0, binary = 0. No done appears. A subsequent 12'h500 conversion -> binary = 500.
- Exhaustive sweep over all valid 3-digit BCD values 000-999 -> binary matches the decimal value each time, and latency is constant.
